resp_checker: RTL

- Response-side companion to the exhaustive stimulus bench for the arithmetic `top` (in1/in2/in3 to out1).
- Each cycle it samples the stimulus triple applied to the combinational DUT together with the DUT's out1, and computes the golden result in a 2-stage pipeline.
- It compares the two, counts mismatches, captures the first failure and reports pass/fail at the end of the sweep.
- It is synthesizable, so it can sit beside the DUT in simulation or on an emulation target.

---
 rtl/resp_chk_pkg.sv | 16 +
 rtl/resp_golden_pipe.sv | 59 +++++
 rtl/resp_checker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/resp_chk_pkg.sv
// rtl/resp_chk_pkg.sv - shared FSM encodings, pipeline depth and MISR constants for resp_checker
package resp_chk_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int unsigned PIPE_DEPTH = 2;

   // x^20 + x^17 + 1 in Galois form; the x^20 term is the implicit feedback
   localparam int unsigned MISR_POLY_W = 20;
   localparam logic [19:0] MISR_TAPS   = 20'h2_0001;
   localparam logic        MISR_SEED_BIT = 1'b1;

endpackage

// File: rtl/resp_golden_pipe.sv
// rtl/resp_golden_pipe.sv - two-stage golden adder with out1/valid/index carried alongside
module resp_golden_pipe #(
   parameter int IN_W  = 19,
   parameter int OUT_W = 20,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vld_i,
   input  logic [IN_W-1:0]  in1_i,
   input  logic [IN_W-1:0]  in2_i,
   input  logic [IN_W-1:0]  in3_i,
   input  logic [OUT_W-1:0] out1_i,
   input  logic [CNT_W-1:0] idx_i,
   output logic             vld_o,
   output logic [OUT_W-1:0] exp_o,
   output logic [OUT_W-1:0] got_o,
   output logic             match_o,
   output logic [CNT_W-1:0] idx_o
);

   logic             s1_vld_q;
   logic [IN_W-1:0]  s1_in1_q, s1_in2_q, s1_in3_q;
   logic [OUT_W-1:0] s1_out1_q;
   logic [CNT_W-1:0] s1_idx_q;
   logic [OUT_W-1:0] sum_d;

   // operands are zero-extended/truncated to OUT_W so the sum wraps mod 2^OUT_W
   assign sum_d = OUT_W'(s1_in1_q) + OUT_W'(s1_in2_q) + OUT_W'(s1_in3_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_in1_q  <= '0;
         s1_in2_q  <= '0;
         s1_in3_q  <= '0;
         s1_out1_q <= '0;
         s1_idx_q  <= '0;
         vld_o     <= 1'b0;
         exp_o     <= '0;
         got_o     <= '0;
         match_o   <= 1'b0;
         idx_o     <= '0;
      end else begin
         s1_vld_q  <= vld_i;
         s1_in1_q  <= in1_i;
         s1_in2_q  <= in2_i;
         s1_in3_q  <= in3_i;
         s1_out1_q <= out1_i;
         s1_idx_q  <= idx_i;
         vld_o     <= s1_vld_q;
         exp_o     <= sum_d;
         got_o     <= s1_out1_q;
         match_o   <= (sum_d == s1_out1_q);
         idx_o     <= s1_idx_q;
      end
   end

endmodule

// File: rtl/resp_checker.sv
// rtl/resp_checker.sv - golden-model response checker with first-fail capture
// Optional RESP_MISR_EN adds a signature output compacting every checked out1.
module resp_checker
   import resp_chk_pkg::*;
#(
   parameter int IN_W  = 19,
   parameter int OUT_W = 20,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             vec_valid,
   input  logic             vec_last,
   input  logic [IN_W-1:0]  in1,
   input  logic [IN_W-1:0]  in2,
   input  logic [IN_W-1:0]  in3,
   input  logic [OUT_W-1:0] out1,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] fail_idx,
   output logic [OUT_W-1:0] fail_got,
   output logic [OUT_W-1:0] fail_exp
`ifdef RESP_MISR_EN
   ,
   output logic [OUT_W-1:0] signature
`endif
);

   logic [1:0]       state_q, state_d;
   logic [1:0]       drain_q, drain_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] fail_idx_q, fail_idx_d;
   logic [OUT_W-1:0] fail_got_q, fail_got_d;
   logic [OUT_W-1:0] fail_exp_q, fail_exp_d;

   logic             start_acc, sample;
   logic             s2_vld, s2_match;
   logic [OUT_W-1:0] s2_exp, s2_got;
   logic [CNT_W-1:0] s2_idx;

   assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE);
   assign sample    = vec_valid && (state_q == ST_RUN);

   resp_golden_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .vld_i   (sample),
      .in1_i   (in1),
      .in2_i   (in2),
      .in3_i   (in3),
      .out1_i  (out1),
      .idx_i   (idx_q),
      .vld_o   (s2_vld),
      .exp_o   (s2_exp),
      .got_o   (s2_got),
      .match_o (s2_match),
      .idx_o   (s2_idx)
   );

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         ST_IDLE:  if (start_acc) state_d = ST_RUN;
         ST_RUN: begin
            if (sample && vec_last) begin
               state_d = ST_DRAIN;
               drain_d = '0;
            end
         end
         ST_DRAIN: begin
            // hold until the last sample has left the pipeline and been counted
            if (drain_q == 2'(PIPE_DEPTH - 1)) state_d = ST_DONE;
            else                               drain_d = drain_q + 2'd1;
         end
         default:  if (start_acc) state_d = ST_RUN;
      endcase
   end

   always_comb begin
      idx_d      = idx_q;
      vec_cnt_d  = vec_cnt_q;
      err_cnt_d  = err_cnt_q;
      fail_idx_d = fail_idx_q;
      fail_got_d = fail_got_q;
      fail_exp_d = fail_exp_q;
      if (start_acc) begin
         idx_d      = '0;
         vec_cnt_d  = '0;
         err_cnt_d  = '0;
         fail_idx_d = '0;
         fail_got_d = '0;
         fail_exp_d = '0;
      end else begin
         if (sample) idx_d = idx_q + 1'b1;
         if (s2_vld) begin
            vec_cnt_d = vec_cnt_q + 1'b1;
            if (!s2_match) begin
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
               if (err_cnt_q == '0) begin
                  fail_idx_d = s2_idx;
                  fail_got_d = s2_got;
                  fail_exp_d = s2_exp;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         drain_q    <= '0;
         idx_q      <= '0;
         vec_cnt_q  <= '0;
         err_cnt_q  <= '0;
         fail_idx_q <= '0;
         fail_got_q <= '0;
         fail_exp_q <= '0;
      end else begin
         state_q    <= state_d;
         drain_q    <= drain_d;
         idx_q      <= idx_d;
         vec_cnt_q  <= vec_cnt_d;
         err_cnt_q  <= err_cnt_d;
         fail_idx_q <= fail_idx_d;
         fail_got_q <= fail_got_d;
         fail_exp_q <= fail_exp_d;
      end
   end

   assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done     = (state_q == ST_DONE);
   assign pass     = done && (err_cnt_q == '0);
   assign vec_cnt  = vec_cnt_q;
   assign err_cnt  = err_cnt_q;
   assign fail_idx = fail_idx_q;
   assign fail_got = fail_got_q;
   assign fail_exp = fail_exp_q;

`ifdef RESP_MISR_EN
   logic [OUT_W-1:0] misr_taps;
   logic [OUT_W-1:0] sig_q, sig_d;

   // fold the 20-bit polynomial onto OUT_W bits so other widths still get a full-length register
   always_comb begin
      misr_taps = '0;
      for (int b = 0; b < int'(MISR_POLY_W); b++)
         misr_taps[b % OUT_W] = misr_taps[b % OUT_W] ^ MISR_TAPS[b];
   end

   always_comb begin
      sig_d = sig_q;
      if (start_acc)
         sig_d = {OUT_W{MISR_SEED_BIT}};
      else if (s2_vld)
         sig_d = {sig_q[OUT_W-2:0], 1'b0} ^ (sig_q[OUT_W-1] ? misr_taps : '0) ^ s2_got;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sig_q <= {OUT_W{MISR_SEED_BIT}};
      else     sig_q <= sig_d;
   end

   assign signature = sig_q;
`endif

endmodule
